// File: rtl/sync_debounce_pkg.sv
// Shared types and helpers for the synchronize/debounce/edge front end.
package sync_debounce_pkg;

    typedef enum logic {STABLE, CAND} db_state_t;

    // Width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/bit_synchronizer.sv
// N-flop synchronizer chain with asynchronous active-low clear.
module bit_synchronizer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] chain;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], d};
        end
    end

    assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/sync_debounce_edge.sv
// Synchronizes a raw input, debounces it over STABLE_CYCLES samples and
// emits registered one-cycle rise/fall/glitch pulses alongside the clean level.
module sync_debounce_edge
    import sync_debounce_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic level,
    output logic rise,
    output logic fall,
    output logic glitch
);

    localparam int                CNT_W    = cnt_width(STABLE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s;
    db_state_t        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             level_nxt, rise_nxt, fall_nxt, glitch_nxt;

    bit_synchronizer #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (a),
        .q   (s)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        level_nxt  = level;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        glitch_nxt = 1'b0;
        if (s != level) begin
            if (cnt == CNT_LAST) begin
                level_nxt = s;
                rise_nxt  = s;
                fall_nxt  = ~s;
                cnt_nxt   = '0;
                state_nxt = STABLE;
            end else begin
                cnt_nxt   = cnt + CNT_W'(1);
                state_nxt = CAND;
            end
        end else if (state == CAND) begin
            // Candidate aborted: the run of differing samples was interrupted.
            glitch_nxt = 1'b1;
            cnt_nxt    = '0;
            state_nxt  = STABLE;
        end
    end

    // NOTE: reset clears every register here; there is no memory array to leave unreset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= STABLE;
            cnt    <= '0;
            level  <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
            glitch <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            level  <= level_nxt;
            rise   <= rise_nxt;
            fall   <= fall_nxt;
            glitch <= glitch_nxt;
        end
    end

endmodule
